// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and helpers for the 4-requester round-robin arbiter.
//   NUM_REQ      number of requesters sharing the downstream port
//   arb_state_t  arbiter FSM state (IDLE / BUSY)
//   rr_pick      round-robin winner: first set req bit scanning ptr, ptr+1, ...
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Returns a one-hot vector of the winning requester, or zero when req==0.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [1:0]         ptr);
        logic [NUM_REQ-1:0] pick;
        logic [1:0]         idx;
        logic               found;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4to1.sv
// ---------------------------------------------------------------------------
// MUX4to1
// One-hot select 4:1 data mux (AND-OR form).
//   SEL  in   4         one-hot select; all-zero selects nothing
//   DI0..DI3 in BITWIDTH data inputs
//   DO   out  BITWIDTH  selected data, 0 when SEL==0
// ---------------------------------------------------------------------------
module MUX4to1 #(
    parameter int BITWIDTH = 32
) (
    input  logic [3:0]          SEL,
    input  logic [BITWIDTH-1:0] DI0,
    input  logic [BITWIDTH-1:0] DI1,
    input  logic [BITWIDTH-1:0] DI2,
    input  logic [BITWIDTH-1:0] DI3,
    output logic [BITWIDTH-1:0] DO
);

    always_comb begin
        DO = ({BITWIDTH{SEL[0]}} & DI0)
           | ({BITWIDTH{SEL[1]}} & DI1)
           | ({BITWIDTH{SEL[2]}} & DI2)
           | ({BITWIDTH{SEL[3]}} & DI3);
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter/sequencer in front of a 4:1 one-hot datapath mux.
// A grant is held for a whole burst; the burst ends on an accepted LAST beat,
// when the granted requester drops REQ, or (optionally) at a beat cap.
// One IDLE cycle always separates consecutive grants.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> grant released after MAX_BEATS accepted beats
//   undefined -> bursts unbounded, MAX_BEATS unused
//
// Ports
//   CLK       in   1         clock, rising edge
//   RESET_N   in   1         synchronous active-low reset
//   REQ       in   4         per-requester request (level)
//   LAST      in   4         per-requester last-beat flag
//   DI0..DI3  in   BITWIDTH  requester data
//   GNT       out  4         registered one-hot grant (mux select), 0 when idle
//   ACK       out  4         per-requester beat-accepted strobe
//   DO        out  BITWIDTH  data of granted requester
//   DO_VALID  out  1         downstream valid
//   DO_READY  in   1         downstream ready
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick round-robin winner from REQ starting at PTR
// BUSY  | GNT held; beats pass when REQ[g] & DO_READY; exit -> IDLE
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int BITWIDTH  = 32,
    parameter int MAX_BEATS = 8
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [3:0]          REQ,
    input  logic [3:0]          LAST,
    input  logic [BITWIDTH-1:0] DI0,
    input  logic [BITWIDTH-1:0] DI1,
    input  logic [BITWIDTH-1:0] DI2,
    input  logic [BITWIDTH-1:0] DI3,
    output logic [3:0]          GNT,
    output logic [3:0]          ACK,
    output logic [BITWIDTH-1:0] DO,
    output logic                DO_VALID,
    input  logic                DO_READY
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         g_idx;
    logic               req_g;
    logic               last_g;
    logic               valid_int;
    logic               hs;
    logic               cap_hit;
    logic               burst_done;
    logic [BITWIDTH-1:0] mux_do;

    MUX4to1 #(
        .BITWIDTH(BITWIDTH)
    ) u_mux (
        .SEL (gnt_q),
        .DI0 (DI0),
        .DI1 (DI1),
        .DI2 (DI2),
        .DI3 (DI3),
        .DO  (mux_do)
    );

    // gnt_q is zero or one-hot, so a plain OR-encode gives the index
    assign g_idx = {gnt_q[3] | gnt_q[2], gnt_q[3] | gnt_q[1]};

    // Outputs are forced quiet while reset is asserted so an aborted burst
    // cannot produce a beat in the reset cycle.
    always_comb begin
        req_g     = |(REQ & gnt_q);
        last_g    = |(LAST & gnt_q);
        valid_int = RESET_N & (state_q == BUSY) & req_g;
        hs        = valid_int & DO_READY;
    end

    assign DO_VALID = valid_int;
    assign ACK      = gnt_q & {NUM_REQ{hs}};
    assign DO       = RESET_N ? mux_do : '0;
    assign GNT      = gnt_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_BEATS);

    logic [CNT_W-1:0] beat_cnt_q;

    assign cap_hit = hs & (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            beat_cnt_q <= '0;
        end else if (state_q != BUSY || burst_done) begin
            beat_cnt_q <= '0;
        end else if (hs) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end
`else
    assign cap_hit = 1'b0;
`endif

    // Abandon (REQ[g] low) ends the burst without a beat.
    assign burst_done = (hs & last_g) | ~req_g | cap_hit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|REQ) begin
                    gnt_d   = rr_pick(REQ, ptr_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (burst_done) begin
                    gnt_d   = '0;
                    ptr_d   = g_idx + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
